// File: rtl/uart_txrx.sv
// Full-duplex 8N1-style UART with a fixed clock divider. TX and RX run as
// independent FSMs on one clock; RX input goes through a 2-flop synchronizer.
module uart_txrx #(
  parameter int p_CLK_DIV  = 10,
  parameter int p_WORD_LEN = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_send,
  input  logic [p_WORD_LEN-1:0] i_data,
  output logic                  o_tx,
  output logic                  o_done,
  output logic                  o_active,
  input  logic                  i_rx,
  output logic [p_WORD_LEN-1:0] o_data,
  output logic                  o_ready
);
  localparam int CW = $clog2(p_CLK_DIV);
  localparam int IW = $clog2(p_WORD_LEN + 1);
  localparam logic [CW-1:0] C_LAST = CW'(p_CLK_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(p_CLK_DIV / 2 - 1);
  localparam logic [IW-1:0] I_LAST = IW'(p_WORD_LEN - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  tx_state_e             tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]         tx_idx_q, tx_idx_d;
  logic [p_WORD_LEN-1:0] tx_sh_q, tx_sh_d, tx_sh_shr;
  logic                  tx_q, tx_d, done_q, done_d, active_q, active_d;

  rx_state_e             rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [IW-1:0]         rx_idx_q, rx_idx_d;
  logic [p_WORD_LEN-1:0] rx_sh_q, rx_sh_d, data_q, data_d;
  logic [p_WORD_LEN:0]   rx_shin;
  logic                  rx_s1_q, rx_s2_q, ready_q, ready_d;
  logic                  tx_bit_end, rx_bit_end;

  assign tx_sh_shr  = tx_sh_q >> 1;
  assign rx_shin    = {rx_s2_q, rx_sh_q};
  assign tx_bit_end = (tx_cnt_q == C_LAST);
  assign rx_bit_end = (rx_cnt_q == C_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    active_d   = active_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        active_d = 1'b0;
        if (i_send) begin
          tx_state_d = TX_START;
          tx_sh_d    = i_data;
          tx_d       = 1'b0;
          active_d   = 1'b1;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = '0;
        tx_d       = tx_sh_q[0];
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_idx_q == I_LAST) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_idx_d = tx_idx_q + 1'b1;
          tx_sh_d  = tx_sh_shr;
          tx_d     = tx_sh_shr[0];
        end
      end
      default: if (tx_bit_end) begin
        tx_state_d = TX_IDLE;
        done_d     = 1'b1;
        active_d   = 1'b0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // RX samples at bit centres: half a bit into the start bit, then every full bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == C_HALF) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_sh_d = rx_shin[p_WORD_LEN:1];
        if (rx_idx_q == I_LAST) rx_state_d = RX_STOP;
        else                    rx_idx_d   = rx_idx_q + 1'b1;
      end
      RX_STOP: if (rx_bit_end) begin
        if (rx_s2_q) begin
          data_d     = rx_sh_q;
          ready_d    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_WAIT;
        end
      end
      default: begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      active_q   <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      active_q   <= active_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      rx_s1_q    <= i_rx;
      rx_s2_q    <= rx_s1_q;
    end
  end

  assign o_tx     = tx_q;
  assign o_done   = done_q;
  assign o_active = active_q;
  assign o_data   = data_q;
  assign o_ready  = ready_q;
endmodule

// File: tb/tb_uart_txrx.sv
// Scenario bench for uart_txrx: expected RX words are queued when stimulus is
// driven and compared by a monitor as o_ready pulses.
module tb_uart_txrx;
  localparam int DIV = 10;
  localparam int WL  = 8;

  logic clk = 1'b0;
  logic i_rst, i_send, i_rx, lb, rx_drv;
  logic [WL-1:0] i_data, o_data;
  logic o_tx, o_done, o_active, o_ready;

  int n_chk = 0, n_fail = 0, done_cnt = 0, rdy_cnt = 0;
  logic [WL-1:0] exp_q[$];
  logic prev_ready = 1'b0;

  always #5 clk = ~clk;
  assign i_rx = lb ? o_tx : rx_drv;

  uart_txrx #(.p_CLK_DIV(DIV), .p_WORD_LEN(WL)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_send(i_send), .i_data(i_data),
    .o_tx(o_tx), .o_done(o_done), .o_active(o_active),
    .i_rx(i_rx), .o_data(o_data), .o_ready(o_ready));

  // Scoreboard: every o_ready pops one expected word.
  always @(negedge clk) begin
    logic [WL-1:0] w;
    if (o_done === 1'b1) done_cnt++;
    if (o_ready === 1'b1) begin
      rdy_cnt++;
      n_chk++;
      if (prev_ready) begin
        n_fail++; $display("FAIL ready_width o_ready high 2 cycles, want 1");
      end
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL rx_unexpected got %h want no word", o_data);
      end else begin
        w = exp_q.pop_front();
        if (o_data !== w) begin
          n_fail++; $display("FAIL rx_word got %h want %h", o_data, w);
        end
      end
    end
    prev_ready = (o_ready === 1'b1);
  end

  function automatic logic tx_bit(logic [WL-1:0] d, int b);
    if (b == 0) return 1'b0;
    if (b == WL + 1) return 1'b1;
    return d[b-1];
  endfunction

  task automatic send_word(input logic [WL-1:0] d, input bit expect_rx);
    if (expect_rx) exp_q.push_back(d);
    i_send = 1'b1; i_data = d;
    @(negedge clk);
    i_send = 1'b0;
  endtask

  task automatic wait_done(output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (o_done === 1'b1) begin hit = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic drive_frame(input logic [WL-1:0] d, input logic stop);
    for (int b = 0; b < WL + 2; b++) begin
      rx_drv = (b == WL + 1) ? stop : tx_bit(d, b);
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (o_tx !== 1'b1)     begin n_fail++; $display("FAIL reset_tx got %b want 1", o_tx); end
    n_chk++; if (o_done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", o_done); end
    n_chk++; if (o_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", o_active); end
    n_chk++; if (o_data !== '0)     begin n_fail++; $display("FAIL reset_data got %h want 00", o_data); end
    n_chk++; if (o_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready got %b want 0", o_ready); end
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback;
    logic [WL-1:0] d = 8'hEE;
    bit ok;
    send_word(d, 1'b1);
    for (int c = 0; c < (WL + 2) * DIV; c++) begin
      n_chk++;
      if (o_tx !== tx_bit(d, c / DIV) || o_active !== 1'b1) begin
        n_fail++;
        $display("FAIL lb_frame cyc %0d got tx=%b act=%b want tx=%b act=1", c, o_tx, o_active, tx_bit(d, c / DIV));
      end
      @(negedge clk);
    end
    n_chk++; if (o_done !== 1'b1 || o_active !== 1'b0 || o_tx !== 1'b1) begin
      n_fail++; $display("FAIL lb_end got done=%b act=%b tx=%b want 1 0 1", o_done, o_active, o_tx);
    end
    @(negedge clk);
    n_chk++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL lb_done_pulse got %b want 0", o_done); end
    wait_drain(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL lb_drain pending %0d want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    bit hit, ok;
    send_word(8'h00, 1'b1);
    wait_done(hit); @(negedge clk);
    send_word(8'hFF, 1'b1);
    wait_done(hit); @(negedge clk);
    send_word(8'h55, 1'b1);
    wait_done(hit);
    n_chk++; if (!hit) begin n_fail++; $display("FAIL b2b_done got timeout want done"); end
    send_word(8'hA3, 1'b1);
    n_chk++; if (o_active !== 1'b1 || o_tx !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart got act=%b tx=%b want 1 0", o_active, o_tx);
    end
    wait_done(hit);
    n_chk++; if (!hit) begin n_fail++; $display("FAIL b2b_done2 got timeout want done"); end
    wait_drain(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_drain pending %0d want 0", exp_q.size()); end
  endtask

  task automatic test_ignore_busy;
    bit hit, ok;
    int r0;
    send_word(8'h5A, 1'b1);
    repeat (30) @(negedge clk);
    send_word(8'hC3, 1'b0);
    i_data = 8'h0F;
    wait_done(hit); @(negedge clk);
    r0 = rdy_cnt;
    repeat (5) @(negedge clk);
    n_chk++; if (o_active !== 1'b0) begin n_fail++; $display("FAIL busy_ignore got act=%b want 0", o_active); end
    wait_drain(ok);
    repeat (150) @(negedge clk);
    n_chk++; if (!ok || rdy_cnt != r0) begin
      n_fail++; $display("FAIL busy_rx got pend=%0d extra=%0d want 0 0", exp_q.size(), rdy_cnt - r0);
    end
  endtask

  task automatic test_false_start;
    bit ok;
    int r0 = rdy_cnt;
    lb = 1'b0;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    n_chk++; if (rdy_cnt != r0) begin n_fail++; $display("FAIL false_start got %0d readies want 0", rdy_cnt - r0); end
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1);
    wait_drain(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL false_start_rx pending %0d want 0", exp_q.size()); end
  endtask

  task automatic test_framing;
    bit ok;
    int r0 = rdy_cnt;
    drive_frame(8'h81, 1'b0);
    repeat (20) @(negedge clk);
    n_chk++; if (rdy_cnt != r0 || o_data !== 8'h3C) begin
      n_fail++; $display("FAIL framing got rdy=%0d data=%h want 0 3c", rdy_cnt - r0, o_data);
    end
    exp_q.push_back(8'h42);
    drive_frame(8'h42, 1'b1);
    wait_drain(ok);
    n_chk++; if (!ok || o_data !== 8'h42) begin
      n_fail++; $display("FAIL framing_rx got pend=%0d data=%h want 0 42", exp_q.size(), o_data);
    end
  endtask

  task automatic test_reset_midframe;
    bit hit, ok;
    int d0, r0;
    lb = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_cnt; r0 = rdy_cnt;
    send_word(8'h77, 1'b0);
    repeat (40) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    n_chk++; if (o_tx !== 1'b1 || o_active !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got tx=%b act=%b want 1 0", o_tx, o_active);
    end
    repeat (150) @(negedge clk);
    n_chk++; if (done_cnt != d0 || rdy_cnt != r0 || o_data !== '0) begin
      n_fail++; $display("FAIL rst_mid_quiet got done=%0d rdy=%0d data=%h want 0 0 00", done_cnt - d0, rdy_cnt - r0, o_data);
    end
    send_word(8'h99, 1'b1);
    wait_done(hit);
    n_chk++; if (!hit) begin n_fail++; $display("FAIL rst_resend got timeout want done"); end
    wait_drain(ok);
    n_chk++; if (!ok || o_data !== 8'h99) begin
      n_fail++; $display("FAIL rst_resend_rx got pend=%0d data=%h want 0 99", exp_q.size(), o_data);
    end
  endtask

  initial begin
    lb = 1'b1; rx_drv = 1'b1; i_rst = 1'b1; i_send = 1'b0; i_data = '0;
    test_reset;
    test_loopback;
    test_back_to_back;
    test_ignore_busy;
    test_false_start;
    test_framing;
    test_reset_midframe;
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
